// File: rtl/fifo_control.sv
// Pointer, occupancy and status-flag control for a single-clock FIFO.
// The memory itself lives outside; this block drives its addresses and strobes.
module fifo_control #(
  parameter int ADDR_WIDTH      = 8,
  parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_TH_C = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH_C = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_FULL    = 2'b10
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  drop_s;
  logic [ADDR_WIDTH:0]   count_nxt_s;

  // Strobes are gated by reset so the memory sees no access while reset_L is low.
  always_comb begin
    wr_en_s = push & ~full & reset_L;
    rd_en_s = pop & ~empty & reset_L;
    drop_s  = (push & full) | (pop & empty);
  end

  assign write_enable = wr_en_s;
  assign read_enable  = rd_en_s;

  // Next occupancy and the status state it implies.
  always_comb begin
    count_nxt_s = fifo_count;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = fifo_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = fifo_count - {{ADDR_WIDTH{1'b0}}, 1'b1};
      default: count_nxt_s = fifo_count;
    endcase

    if (count_nxt_s == {(ADDR_WIDTH+1){1'b0}}) begin
      state_nxt_s = ST_EMPTY;
    end else if (count_nxt_s == DEPTH_C) begin
      state_nxt_s = ST_FULL;
    end else begin
      state_nxt_s = ST_PARTIAL;
    end
  end

  // Status FSM with all pointer, count and flag outputs registered alongside it.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r      <= ST_EMPTY;
      wr_ptr       <= {ADDR_WIDTH{1'b0}};
      rd_ptr       <= {ADDR_WIDTH{1'b0}};
      fifo_count   <= {(ADDR_WIDTH+1){1'b0}};
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      // Pointers wrap naturally at 2**ADDR_WIDTH.
      if (wr_en_s) wr_ptr <= wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (rd_en_s) rd_ptr <= rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      fifo_count   <= count_nxt_s;
      case (state_nxt_s)
        ST_EMPTY:   begin empty <= 1'b1; full <= 1'b0; end
        ST_FULL:    begin empty <= 1'b0; full <= 1'b1; end
        ST_PARTIAL: begin empty <= 1'b0; full <= 1'b0; end
        default:    begin empty <= 1'b1; full <= 1'b0; end
      endcase
      almost_full  <= (count_nxt_s >= AF_TH_C);
      almost_empty <= (count_nxt_s <= AE_TH_C);
      error        <= error | drop_s;
    end
  end

endmodule

// File: tb/tb_fifo_control.sv
// Directed self-checking bench for fifo_control at ADDR_WIDTH=3 (depth 8, thresholds 6/2).
module tb_fifo_control;

  logic       clk;
  logic       reset_L;
  logic       push;
  logic       pop;
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic       write_enable;
  logic       read_enable;
  logic [3:0] fifo_count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;

  int checks;
  int failures;

  fifo_control #(
    .ADDR_WIDTH      (3),
    .ALMOST_FULL_TH  (6),
    .ALMOST_EMPTY_TH (2)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .pop          (pop),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_L  = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    #1;
    reset_L  = 1'b0;
    push     = 1'b1;
    pop      = 1'b1;
    #2;
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_write_enable", 32'(write_enable), 32'd0);
    chk("rst_read_enable", 32'(read_enable), 32'd0);
    tick();
    chk("rst_hold_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;

    // Single push from reset
    push = 1'b1;
    #1;
    chk("p1_write_enable", 32'(write_enable), 32'd1);
    tick();
    chk("p1_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("p1_count", 32'(fifo_count), 32'd1);
    chk("p1_empty", 32'(empty), 32'd0);
    chk("p1_almost_empty", 32'(almost_empty), 32'd1);
    chk("p1_error", 32'(error), 32'd0);

    // Fill to depth, tracking threshold flags at each occupancy
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("fill_count_%0d", i), 32'(fifo_count), 32'(i));
      chk($sformatf("fill_af_%0d", i), 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      chk($sformatf("fill_ae_%0d", i), 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_wr_ptr_wrap", 32'(wr_ptr), 32'd0);
    chk("full_error", 32'(error), 32'd0);

    // Ninth push is dropped
    chk("ovf_write_enable", 32'(write_enable), 32'd0);
    tick();
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("ovf_error", 32'(error), 32'd1);

    // Push+pop while full: only the pop is taken
    pop = 1'b1;
    #1;
    chk("fpp_read_enable", 32'(read_enable), 32'd1);
    chk("fpp_write_enable", 32'(write_enable), 32'd0);
    tick();
    chk("fpp_count", 32'(fifo_count), 32'd7);
    chk("fpp_rd_ptr", 32'(rd_ptr), 32'd1);
    chk("fpp_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("fpp_full", 32'(full), 32'd0);
    chk("fpp_error", 32'(error), 32'd1);

    // Underflow from reset, then push+pop while empty
    push = 1'b0;
    pop  = 1'b0;
    pulse_reset();
    chk("r2_error", 32'(error), 32'd0);
    pop = 1'b1;
    #1;
    chk("unf_read_enable", 32'(read_enable), 32'd0);
    tick();
    chk("unf_count", 32'(fifo_count), 32'd0);
    chk("unf_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("unf_error", 32'(error), 32'd1);
    push = 1'b1;
    #1;
    chk("epp_write_enable", 32'(write_enable), 32'd1);
    chk("epp_read_enable", 32'(read_enable), 32'd0);
    tick();
    chk("epp_count", 32'(fifo_count), 32'd1);
    chk("epp_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("epp_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("epp_empty", 32'(empty), 32'd0);

    // Word written last edge is readable now
    push = 1'b0;
    #1;
    chk("lat_read_enable", 32'(read_enable), 32'd1);
    tick();
    chk("lat_count", 32'(fifo_count), 32'd0);
    chk("lat_empty", 32'(empty), 32'd1);
    chk("lat_rd_ptr", 32'(rd_ptr), 32'd1);
    pop = 1'b0;

    // Steady push+pop at occupancy 4
    pulse_reset();
    push = 1'b1;
    repeat (4) tick();
    chk("s4_count", 32'(fifo_count), 32'd4);
    pop = 1'b1;
    repeat (10) tick();
    chk("ss_count", 32'(fifo_count), 32'd4);
    chk("ss_wr_ptr", 32'(wr_ptr), 32'd6);
    chk("ss_rd_ptr", 32'(rd_ptr), 32'd2);
    chk("ss_empty", 32'(empty), 32'd0);
    chk("ss_full", 32'(full), 32'd0);
    chk("ss_almost_full", 32'(almost_full), 32'd0);
    chk("ss_almost_empty", 32'(almost_empty), 32'd0);
    chk("ss_error", 32'(error), 32'd0);

    // Mid-operation reset at occupancy 5, checked before the next edge
    pop = 1'b0;
    tick();
    chk("m5_count", 32'(fifo_count), 32'd5);
    push = 1'b0;
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    chk("mr_count", 32'(fifo_count), 32'd0);
    chk("mr_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("mr_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_almost_empty", 32'(almost_empty), 32'd1);
    reset_L = 1'b1;
    push    = 1'b1;
    tick();
    push = 1'b0;
    chk("mr_post_count", 32'(fifo_count), 32'd1);
    chk("mr_post_wr_ptr", 32'(wr_ptr), 32'd1);
    chk("mr_post_empty", 32'(empty), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_control.md
FIFO_CONTROL -- requirements
Module: fifo_control

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, memory address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-002 Parameter ALMOST_FULL_TH, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-003 Parameter ALMOST_EMPTY_TH, default 2, occupancy at or below which almost_empty asserts.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 push  input  1  upstream write request, sampled at rising clk.
REQ-007 pop  input  1  downstream read request, sampled at rising clk.
REQ-008 wr_ptr  output  ADDR_WIDTH  write address to memory, registered.
REQ-009 rd_ptr  output  ADDR_WIDTH  read address to memory, registered.
REQ-010 write_enable  output  1  memory write strobe, combinational.
REQ-011 read_enable  output  1  memory read strobe, combinational.
REQ-012 fifo_count  output  ADDR_WIDTH+1  current occupancy 0..DEPTH, registered.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags, registered.
REQ-014 error  output  1  sticky overflow/underflow flag, registered.

Function
REQ-015 write_enable SHALL equal push AND NOT full; read_enable SHALL equal pop AND NOT empty.
REQ-016 Accepted push: wr_ptr increments by 1 at the next rising edge; accepted pop: rd_ptr increments by 1 at the next rising edge.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 by natural modulo-2**ADDR_WIDTH arithmetic.
REQ-018 fifo_count SHALL increment on push-only, decrement on pop-only, hold on both-accepted or neither.
REQ-019 Status FSM states EMPTY (count 0), PARTIAL (1..DEPTH-1), FULL (count DEPTH); state SHALL be derived from next count and registered.
REQ-020 Transitions: EMPTY->PARTIAL on accepted push; PARTIAL->FULL when count reaches DEPTH; PARTIAL->EMPTY when count reaches 0; FULL->PARTIAL on accepted pop.
REQ-021 empty = (state==EMPTY), full = (state==FULL), registered with state.
REQ-022 almost_full = (count >= ALMOST_FULL_TH); almost_empty = (count <= ALMOST_EMPTY_TH); both registered from next count.
REQ-023 Push while full SHALL be dropped (no pointer/count change) even with simultaneous pop; pop SHALL still be accepted.
REQ-024 Pop while empty SHALL be dropped even with simultaneous push; push SHALL still be accepted.
REQ-025 A dropped push or pop SHALL set error at the next rising edge; error SHALL remain 1 until reset.
REQ-026 Push and pop both accepted in PARTIAL: both pointers advance, count and flags unchanged.
REQ-027 Latency: a word written at edge N SHALL be readable (read_enable asserted, empty=0) starting cycle N+1.

Reset
REQ-028 reset_L low SHALL immediately, independent of clk, force wr_ptr=0, rd_ptr=0, fifo_count=0, state EMPTY, empty=1, almost_empty=1, full=0, almost_full=0, error=0.
REQ-029 During reset, write_enable and read_enable SHALL be 0 regardless of push/pop.
REQ-030 Reset asserted mid-operation SHALL discard all occupancy; first edge after release SHALL behave as from power-up.

Verification (ADDR_WIDTH=3, DEPTH=8, thresholds 6/2)
REQ-031 Reset then push 1 cycle -> wr_ptr=1, count=1, empty=0, almost_empty=1, error=0.
REQ-032 Push 8 consecutive cycles from reset -> count=8, full=1, almost_full=1, wr_ptr=0 (wrapped); 9th push -> write_enable=0, count=8, error=1.
REQ-033 From full, push+pop same cycle -> read_enable=1, write_enable=0, count=7, rd_ptr=1, full=0, error=1.
REQ-034 From reset, pop alone -> read_enable=0, count=0, error=1; then push+pop together -> count=1, rd_ptr=0.
REQ-035 Count=4, push+pop 10 cycles -> count=4, wr_ptr and rd_ptr each advanced by 10 mod 8 (=2), flags unchanged.
REQ-036 Count=5, reset_L pulsed low between edges -> outputs at reset values before next edge; next push gives count=1, wr_ptr=1.
